// File: rtl/mux_scan_ctrl.sv
// Round-robin select sequencer for a 4:1 mux: settle, sample Y, emit {ch,data}.
// Optional MUX_SCAN_CHANGE_ONLY_EN suppresses samples equal to the last one emitted.
module mux_scan_ctrl #(
  parameter int DATA_W = 2,
  parameter int DWELL  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [3:0]        MASK,
  input  logic [DATA_W-1:0] Y,
  output logic [1:0]        S,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [1:0]        OUT_CH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              BUSY
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          s_q, s_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [1:0]          out_ch_q, out_ch_d;
  logic                out_valid_q, out_valid_d;
  logic                sel_go;
  logic                resel;
  logic [1:0]          nxt;

`ifdef MUX_SCAN_CHANGE_ONLY_EN
  logic [DATA_W-1:0]   last_q [4];
  logic [DATA_W-1:0]   last_d [4];
  logic [3:0]          seen_q, seen_d;
`endif

  // First enabled channel after ptr, wrapping; offset 4 lands on ptr itself.
  function automatic logic [1:0] pick(input logic [1:0] ptr,
                                      input logic [3:0] mask);
    logic [1:0] c;
    logic [1:0] r;
    r = ptr;
    for (int i = 4; i >= 1; i--) begin
      c = ptr + 2'(i);
      if (mask[c]) r = c;
    end
    return r;
  endfunction

  assign sel_go = EN && (MASK != 4'b0000);
  assign nxt    = pick(ptr_q, MASK);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    resel       = 1'b0;
`ifdef MUX_SCAN_CHANGE_ONLY_EN
    last_d      = last_q;
    seen_d      = seen_q;
`endif
    unique case (state_q)
      IDLE: begin
        resel = 1'b1;
      end
      SETTLE: begin
        if (!EN) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
`ifdef MUX_SCAN_CHANGE_ONLY_EN
          if (seen_q[s_q] && (Y == last_q[s_q])) begin
            resel = 1'b1;
          end else begin
            out_data_d  = Y;
            out_ch_d    = s_q;
            out_valid_d = 1'b1;
            state_d     = HOLD;
            last_d[s_q] = Y;
            seen_d[s_q] = 1'b1;
          end
`else
          out_data_d  = Y;
          out_ch_d    = s_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
`endif
        end
      end
      HOLD: begin
        if (out_valid_q && OUT_READY) begin
          out_valid_d = 1'b0;
          resel       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (resel) begin
      if (sel_go) begin
        ptr_d   = nxt;
        s_d     = nxt;
        cnt_d   = CNT_W'(DWELL - 1);
        state_d = SETTLE;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd3;
      s_q         <= 2'd0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef MUX_SCAN_CHANGE_ONLY_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      seen_q <= 4'b0000;
      for (int i = 0; i < 4; i++) last_q[i] <= '0;
    end else begin
      seen_q <= seen_d;
      for (int i = 0; i < 4; i++) last_q[i] <= last_d[i];
    end
  end
`endif

  assign S         = s_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_CH    = out_ch_q;
  assign OUT_VALID = out_valid_q;
  assign BUSY      = (state_q != IDLE);

endmodule
